// File: rtl/enemy_wave_control_pkg.sv
// Shared types and helpers for the enemy wave controller.
package enemy_wave_control_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSpawn,
      StFight,
      StClear
   } wave_state_e;

   // Wave targets are kept within 1..n_planes so a wave always spawns something.
   function automatic int unsigned clamp_target(input int unsigned value,
                                                input int unsigned n_planes);
      if (value == 0) begin
         return 1;
      end
      if (value > n_planes) begin
         return n_planes;
      end
      return value;
   endfunction

endpackage

// File: rtl/enemy_wave_control_if.sv
// Control/status bundle between the game-state FSM, the wave controller and the draw path.
interface enemy_wave_control_if #(
   parameter int unsigned N_PLANES = 10,
   parameter int unsigned CNT_W    = 4,
   parameter int unsigned LVL_W    = 4
);
   logic                start;
   logic                abort;
   logic                tick;
   logic [CNT_W-1:0]    init_amount;
   logic [N_PLANES-1:0] kill;
   logic [N_PLANES-1:0] vis;
   logic [CNT_W-1:0]    active_count;
   logic [LVL_W-1:0]    level;
   logic                wave_clear;
   logic                busy;

   modport master (
      output start, abort, tick, init_amount, kill,
      input  vis, active_count, level, wave_clear, busy
   );

   modport slave (
      input  start, abort, tick, init_amount, kill,
      output vis, active_count, level, wave_clear, busy
   );
endinterface

// File: rtl/enemy_wave_control_lowest_zero_pick.sv
// Lowest-zero picker: one-hot of the lowest clear slot, plus a flag when every slot is taken.
module enemy_wave_control_lowest_zero_pick #(
   parameter int unsigned N_PLANES = 10
) (
   input  logic [N_PLANES-1:0] vis,
   output logic [N_PLANES-1:0] pick,
   output logic                none_free
);

   // Priority scan from bit 0 upward; none_free doubles as the "not yet found" flag.
   always_comb begin
      pick      = '0;
      none_free = 1'b1;
      for (int i = 0; i < N_PLANES; i++) begin
         if (none_free && !vis[i]) begin
            pick[i]   = 1'b1;
            none_free = 1'b0;
         end
      end
   end

endmodule

// File: rtl/enemy_wave_control.sv
// Enemy wave controller: paced spawning, kill handling and wave escalation for N_PLANES slots.
module enemy_wave_control
   import enemy_wave_control_pkg::*;
#(
   parameter int unsigned N_PLANES   = 10,
   parameter int unsigned CNT_W      = 4,
   parameter int unsigned SPAWN_GAP  = 30,
   parameter int unsigned CLEAR_HOLD = 60,
   parameter int unsigned LVL_W      = 4
) (
   input logic                 clock,
   input logic                 resetn,
   enemy_wave_control_if.slave bus
);

   localparam int unsigned GAP_W  = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
   localparam int unsigned HOLD_W = (CLEAR_HOLD > 1) ? $clog2(CLEAR_HOLD) : 1;
   localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(SPAWN_GAP - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(CLEAR_HOLD - 1);
   localparam logic [CNT_W-1:0]  TARGET_MAX = CNT_W'(N_PLANES);
   localparam logic [LVL_W-1:0]  LEVEL_MAX  = '1;

   wave_state_e         state_q;
   logic [N_PLANES-1:0] vis_q;
   logic [CNT_W-1:0]    active_count_q;
   logic [CNT_W-1:0]    target_q;
   logic [CNT_W-1:0]    spawned_q;
   logic [LVL_W-1:0]    level_q;
   logic [GAP_W-1:0]    gap_q;
   logic [HOLD_W-1:0]   hold_q;
   logic                wave_clear_q;
   logic                busy_q;

   logic [N_PLANES-1:0] pick;
   logic                none_free;
   logic                spawn_due;
   logic [N_PLANES-1:0] spawn_bit;
   logic [N_PLANES-1:0] kill_eff;
   logic [N_PLANES-1:0] vis_next;
   logic [CNT_W-1:0]    spawned_next;
   logic [CNT_W-1:0]    count_next;

   enemy_wave_control_lowest_zero_pick #(
      .N_PLANES (N_PLANES)
   ) u_pick (
      .vis       (vis_q),
      .pick      (pick),
      .none_free (none_free)
   );

   // Next mask: kills clear bits, a due spawn sets the lowest free bit (spawn wins on its bit).
   always_comb begin
      spawn_due    = (state_q == StSpawn) && bus.tick && (gap_q == '0) &&
                     (spawned_q != target_q) && !none_free;
      spawn_bit    = spawn_due ? pick : '0;
      kill_eff     = ((state_q == StSpawn) || (state_q == StFight)) ? bus.kill : '0;
      vis_next     = (vis_q & ~kill_eff) | spawn_bit;
      spawned_next = spawned_q + CNT_W'(spawn_due);
   end

   // Popcount of the next mask so active_count lands in the same cycle as vis.
   always_comb begin
      count_next = '0;
      for (int i = 0; i < N_PLANES; i++) begin
         count_next = count_next + CNT_W'(vis_next[i]);
      end
   end

   // Wave FSM with registered outputs; abort behaves like a synchronous reset.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q        <= StIdle;
         vis_q          <= '0;
         active_count_q <= '0;
         target_q       <= '0;
         spawned_q      <= '0;
         level_q        <= '0;
         gap_q          <= '0;
         hold_q         <= '0;
         wave_clear_q   <= 1'b0;
         busy_q         <= 1'b0;
      end else if (bus.abort) begin
         state_q        <= StIdle;
         vis_q          <= '0;
         active_count_q <= '0;
         target_q       <= '0;
         spawned_q      <= '0;
         level_q        <= '0;
         gap_q          <= '0;
         hold_q         <= '0;
         wave_clear_q   <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         wave_clear_q   <= 1'b0;
         vis_q          <= vis_next;
         active_count_q <= count_next;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  target_q  <= CNT_W'(clamp_target(32'(bus.init_amount), N_PLANES));
                  level_q   <= LVL_W'(1);
                  spawned_q <= '0;
                  gap_q     <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= StSpawn;
               end
            end
            StSpawn: begin
               if (bus.tick) begin
                  if (gap_q != '0) begin
                     gap_q <= gap_q - GAP_W'(1);
                  end else if (spawn_due) begin
                     gap_q <= GAP_RELOAD;
                  end
               end
               spawned_q <= spawned_next;
               if (spawned_next == target_q) begin
                  if (vis_next == '0) begin
                     state_q      <= StClear;
                     wave_clear_q <= 1'b1;
                     hold_q       <= '0;
                  end else begin
                     state_q <= StFight;
                  end
               end
            end
            StFight: begin
               if (vis_next == '0) begin
                  state_q      <= StClear;
                  wave_clear_q <= 1'b1;
                  hold_q       <= '0;
               end
            end
            StClear: begin
               if (bus.tick) begin
                  if (hold_q == HOLD_LAST) begin
                     target_q  <= (target_q >= TARGET_MAX) ? TARGET_MAX : target_q + CNT_W'(1);
                     level_q   <= (level_q == LEVEL_MAX) ? LEVEL_MAX : level_q + LVL_W'(1);
                     spawned_q <= '0;
                     gap_q     <= '0;
                     state_q   <= StSpawn;
                  end else begin
                     hold_q <= hold_q + HOLD_W'(1);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.vis          = vis_q;
   assign bus.active_count = active_count_q;
   assign bus.level        = level_q;
   assign bus.wave_clear   = wave_clear_q;
   assign bus.busy         = busy_q;

endmodule

// File: doc/enemy_wave_control.md
Name: enemy_wave_control

Overview:
Sequential successor to the combinational plane-count-to-visibility decoder. It produces the per-plane visibility mask for N_PLANES enemy slots. Planes are spawned one at a time at a paced interval until the wave's target count is reached. Individual kills clear their bits, and the wave auto-escalates (target+1, level+1) after each clear. It sits between the game-state FSM (start/abort/frame tick) and the enemy draw/collision datapath.

Parameters:
N_PLANES, 10, number of enemy slots (width of vis)
CNT_W, 4, width of count fields; must satisfy 2^CNT_W > N_PLANES
SPAWN_GAP, 30, frame ticks between successive spawns (>=1)
CLEAR_HOLD, 60, frame ticks spent in CLEAR before the next wave (>=1)
LVL_W, 4, width of level counter

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; begins wave 1 (honoured only in IDLE)
abort  in  1  synchronous; return to IDLE, clear mask (priority over all but reset)
tick  in  1  1-cycle frame-rate enable; all pacing counts ticks only
init_amount  in  CNT_W  first-wave target, sampled on start
kill  in  N_PLANES  per-slot kill pulses from collision logic
vis  out  N_PLANES  visibility mask, registered
active_count  out  CNT_W  popcount of vis, registered, same cycle as vis
level  out  LVL_W  current wave number, 1-based
wave_clear  out  1  1-cycle pulse on entering CLEAR
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, resetn=0): state=IDLE, vis=0, active_count=0, level=0, wave_clear=0, busy=0. All counters are cleared.
- Target clamp: a value of 0 maps to 1; a value >N_PLANES maps to N_PLANES. The clamped value is stored in the target register.
- IDLE, start=1: latch clamp(init_amount), level=1, spawned=0, gap counter=0, go to SPAWN. start in any other state is ignored.
- SPAWN, on tick with gap counter==0: set the lowest-index zero bit of vis, spawned+=1, reload gap counter to SPAWN_GAP-1. On other ticks, decrement the gap counter.
  - The first spawn occurs on the first tick after entering SPAWN.
  - When spawned==target, go to FIGHT; no further spawns this wave.
  - If vis is all-ones when a spawn is due, the spawn is deferred (spawned is not incremented) until a bit frees.
- Kill: vis_next = (vis & ~kill) | spawn_bit. This applies in SPAWN and FIGHT.
  - Kill on an already-clear bit is ignored.
  - A spawn into a bit that is killed in the same cycle leaves that bit set, because spawn wins on the new bit.
  - Kill is ignored in IDLE and CLEAR.
- FIGHT: when vis_next==0, go to CLEAR and assert wave_clear for exactly 1 cycle.
- SPAWN with spawned==target and vis_next==0 in the same cycle: go directly to CLEAR.
- CLEAR: count CLEAR_HOLD ticks. Then:
  - target = min(target+1, N_PLANES)
  - level += 1, saturating at 2^LVL_W-1
  - spawned = 0, gap counter = 0
  - go to SPAWN
- abort=1 in any state: next cycle state=IDLE, vis=0, active_count=0, level=0, wave_clear=0. Pending counters are cleared.
- Latency: a kill or spawn is reflected on vis and active_count one clock after the triggering cycle. wave_clear is asserted in the cycle the state register shows CLEAR.
- active_count is computed from vis_next and registered, so it is never stale relative to vis.
- Simultaneous tick+kill: both apply in the same cycle.

Decomposition:
- Shared package holds the state encoding (IDLE, SPAWN, FIGHT, CLEAR) and the clamp function (CNT_W-wide, parameterised by N_PLANES).
- One sub-module: lowest_zero_pick. It is combinational, N_PLANES wide, and outputs a one-hot of the lowest clear bit plus a none_free flag.
- The popcount stays inline.

Test Plan:
- Reset: hold resetn=0 mid-SPAWN with vis=0b111 -> vis=0, level=0, busy=0 asynchronously, before the next clock edge.
- Clamp and spawn pacing: init_amount=0, start, SPAWN_GAP=2 -> vis=0b1 after the first tick and never exceeds 1; init_amount=12 -> target=10, and vis reaches 0x3FF after 10 spawns spaced 2 ticks apart.
- Kill and refill: target=3, vis=0b011, kill=0b001 on the same cycle as a due spawn -> vis=0b110, active_count=2. The next spawn is suppressed because spawned already equals 3.
- Wave clear: target=2, all planes spawned, kill=0b011 -> state=FIGHT→CLEAR, wave_clear high for 1 cycle, vis=0. After CLEAR_HOLD ticks: level=2, target=3, SPAWN begins.
- Saturation: target=10 at clear -> next target stays 10; level=15 at clear -> stays 15.
- Abort and ignored start: abort during FIGHT with vis=0b101 -> IDLE, vis=0 the next cycle. start pulsed during SPAWN -> no change to level or target.
